axis_fifo_ingress: RTL and testbench

AXI-Stream ingress stage that sits directly upstream of the 45-bit `fifo` block. It accepts one AXIS beat per cycle and packs the sideband into the FIFO word format. A 2-entry skid buffer decouples `s_tready` from the FIFO's `w_rdy`. It enforces a maximum packet length by forcing `tlast`, and optionally counts packets written into the FIFO.

---
 rtl/fsic_axis_pkg.sv | 18 +
 rtl/axis_skid2.sv | 71 +++++++
 rtl/axis_fifo_ingress.sv | 78 +++++++
 tb/tb_axis_fifo_ingress.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fsic_axis_pkg.sv
// rtl/fsic_axis_pkg.sv - shared AXIS word layout and ingress buffer state type
package fsic_axis_pkg;

    localparam int AXIS_WORD_W = 45;
    localparam int TDATA_LSB   = 0;
    localparam int TSTRB_LSB   = 32;
    localparam int TKEEP_LSB   = 36;
    localparam int TLAST_BIT   = 40;
    localparam int TUSER_LSB   = 41;
    localparam int TID_LSB     = 43;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } ingress_st_t;

endpackage

// File: rtl/axis_skid2.sv
// rtl/axis_skid2.sv - generic 2-entry skid buffer with registered ready/valid
module axis_skid2
    import fsic_axis_pkg::*;
#(
    parameter int W = AXIS_WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_tdata,
    input  logic         in_tvalid,
    output logic         in_tready,
    output logic [W-1:0] out_tdata,
    output logic         out_tvalid,
    input  logic         out_tready
);

    ingress_st_t  st;
    logic [W-1:0] skid_q;
    logic         acc;
    logic         drn;

    assign acc = in_tvalid & in_tready;
    assign drn = out_tvalid & out_tready;

    // in_tready/out_tvalid are registered copies of (next state != TWO/EMPTY)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_EMPTY;
            out_tdata  <= '0;
            skid_q     <= '0;
            in_tready  <= 1'b0;
            out_tvalid <= 1'b0;
        end else begin
            case (st)
                ST_EMPTY: begin
                    in_tready <= 1'b1;
                    if (acc) begin
                        out_tdata  <= in_tdata;
                        out_tvalid <= 1'b1;
                        st         <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && !drn) begin
                        skid_q    <= in_tdata;
                        in_tready <= 1'b0;
                        st        <= ST_TWO;
                    end else if (acc && drn) begin
                        out_tdata <= in_tdata;
                    end else if (drn) begin
                        out_tvalid <= 1'b0;
                        st         <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drn) begin
                        out_tdata <= skid_q;
                        in_tready <= 1'b1;
                        st        <= ST_ONE;
                    end
                end
                default: begin
                    in_tready  <= 1'b0;
                    out_tvalid <= 1'b0;
                    st         <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/axis_fifo_ingress.sv
// rtl/axis_fifo_ingress.sv - AXIS ingress packer with length limit; FSIC_INGRESS_PKT_CNT_EN enables pkt_cnt
module axis_fifo_ingress
    import fsic_axis_pkg::*;
#(
    parameter int MAX_BEATS = 64,
    parameter int WIDTH     = 45
) (
    input  logic             axis_clk,
    input  logic             axi_reset_n,
    input  logic [31:0]      s_tdata,
    input  logic [3:0]       s_tstrb,
    input  logic [3:0]       s_tkeep,
    input  logic [1:0]       s_tuser,
    input  logic [1:0]       s_tid,
    input  logic             s_tlast,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic             w_vld,
    input  logic             w_rdy,
    output logic [WIDTH-1:0] data_in,
    input  logic             err_clr,
    output logic             err_oversize,
    output logic [15:0]      pkt_cnt
);

    localparam logic [15:0] LIMIT = 16'(MAX_BEATS - 1);

    logic [AXIS_WORD_W-1:0] packed_word;
    logic [15:0]            beat_cnt;
    logic                   acc;
    logic                   at_limit;

    assign acc      = s_tvalid & s_tready;
    assign at_limit = (beat_cnt == LIMIT);

    assign packed_word[TDATA_LSB +: 32] = s_tdata;
    assign packed_word[TSTRB_LSB +: 4]  = s_tstrb;
    assign packed_word[TKEEP_LSB +: 4]  = s_tkeep;
    assign packed_word[TLAST_BIT]       = s_tlast | at_limit;
    assign packed_word[TUSER_LSB +: 2]  = s_tuser;
    assign packed_word[TID_LSB +: 2]    = s_tid;

    // A truncation in the same cycle as err_clr keeps the flag set
    always_ff @(posedge axis_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            beat_cnt     <= '0;
            err_oversize <= 1'b0;
        end else begin
            if (acc) begin
                if (s_tlast || at_limit) beat_cnt <= '0;
                else                     beat_cnt <= beat_cnt + 16'd1;
            end
            if (acc && !s_tlast && at_limit) err_oversize <= 1'b1;
            else if (err_clr)                err_oversize <= 1'b0;
        end
    end

    axis_skid2 #(.W(AXIS_WORD_W)) u_skid (
        .clk        (axis_clk),
        .rst_n      (axi_reset_n),
        .in_tdata   (packed_word),
        .in_tvalid  (s_tvalid),
        .in_tready  (s_tready),
        .out_tdata  (data_in),
        .out_tvalid (w_vld),
        .out_tready (w_rdy)
    );

`ifdef FSIC_INGRESS_PKT_CNT_EN
    always_ff @(posedge axis_clk or negedge axi_reset_n) begin
        if (!axi_reset_n)                         pkt_cnt <= '0;
        else if (w_vld && w_rdy && data_in[TLAST_BIT]) pkt_cnt <= pkt_cnt + 16'd1;
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_fifo_ingress.sv
// tb/tb_axis_fifo_ingress.sv - self-checking bench for axis_fifo_ingress (MAX_BEATS 64 and 4 instances)
module tb_axis_fifo_ingress;

    logic        axis_clk = 1'b0;
    logic        axi_reset_n = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic [3:0]  s_tkeep = '0;
    logic [1:0]  s_tuser = '0;
    logic [1:0]  s_tid = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        w_rdy = 1'b0;
    logic        err_clr = 1'b0;

    logic        rdy_a, rdy_b, vld_a, vld_b, err_a, err_b;
    logic [44:0] din_a, din_b;
    logic [15:0] pkt_a, pkt_b;

    int tests = 0;
    int fails = 0;

    logic [44:0] qa[$];
    logic [44:0] qb[$];
    int          cnta, cntb;
    logic        erra, errb, rdy_ok;
    logic [15:0] pkta, pktb;

    always #5 axis_clk = ~axis_clk;

    axis_fifo_ingress #(.MAX_BEATS(64), .WIDTH(45)) dut_a (
        .axis_clk(axis_clk), .axi_reset_n(axi_reset_n), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
        .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tid(s_tid), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
        .s_tready(rdy_a), .w_vld(vld_a), .w_rdy(w_rdy), .data_in(din_a), .err_clr(err_clr),
        .err_oversize(err_a), .pkt_cnt(pkt_a));

    axis_fifo_ingress #(.MAX_BEATS(4), .WIDTH(45)) dut_b (
        .axis_clk(axis_clk), .axi_reset_n(axi_reset_n), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
        .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tid(s_tid), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
        .s_tready(rdy_b), .w_vld(vld_b), .w_rdy(w_rdy), .data_in(din_b), .err_clr(err_clr),
        .err_oversize(err_b), .pkt_cnt(pkt_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] pack(input logic [1:0] id, input logic [1:0] us, input logic l,
                                         input logic [3:0] kp, input logic [3:0] st, input logic [31:0] d);
        return {id, us, l, kp, st, d};
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        cnta = 0; cntb = 0;
        erra = 1'b0; errb = 1'b0;
        pkta = '0; pktb = '0;
        rdy_ok = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".rdy_a"}, 64'(rdy_a), 64'(rdy_ok && qa.size() < 2));
        chk({tag, ".rdy_b"}, 64'(rdy_b), 64'(rdy_ok && qb.size() < 2));
        chk({tag, ".vld_a"}, 64'(vld_a), 64'(qa.size() > 0));
        chk({tag, ".vld_b"}, 64'(vld_b), 64'(qb.size() > 0));
        if (qa.size() > 0) chk({tag, ".din_a"}, 64'(din_a), 64'(qa[0]));
        if (qb.size() > 0) chk({tag, ".din_b"}, 64'(din_b), 64'(qb[0]));
        chk({tag, ".err_a"}, 64'(err_a), 64'(erra));
        chk({tag, ".err_b"}, 64'(err_b), 64'(errb));
        chk({tag, ".pkt_a"}, 64'(pkt_a), 64'(pkta));
        chk({tag, ".pkt_b"}, 64'(pkt_b), 64'(pktb));
    endtask

    // One clock: drive inputs, advance the reference model, compare after the edge
    task automatic step(input string tag, input logic v, input logic [31:0] d, input logic [3:0] st,
                        input logic [3:0] kp, input logic [1:0] us, input logic [1:0] id,
                        input logic l, input logic wr, input logic clr);
        logic acc, drn, fa, fb;
        s_tvalid = v; s_tdata = d; s_tstrb = st; s_tkeep = kp; s_tuser = us; s_tid = id;
        s_tlast = l; w_rdy = wr; err_clr = clr;
        acc = v && rdy_ok && qa.size() < 2;
        drn = qa.size() > 0 && wr;
        @(posedge axis_clk);
        #1;
        if (drn) begin
`ifdef FSIC_INGRESS_PKT_CNT_EN
            if (qa[0][40]) pkta = pkta + 16'd1;
            if (qb[0][40]) pktb = pktb + 16'd1;
`endif
            void'(qa.pop_front());
            void'(qb.pop_front());
        end
        fa = acc && (l || cnta == 63);
        fb = acc && (l || cntb == 3);
        if (acc && !l && cnta == 63) erra = 1'b1;
        else if (clr)                erra = 1'b0;
        if (acc && !l && cntb == 3)  errb = 1'b1;
        else if (clr)                errb = 1'b0;
        if (acc) begin
            qa.push_back(pack(id, us, fa, kp, st, d));
            qb.push_back(pack(id, us, fb, kp, st, d));
            cnta = fa ? 0 : cnta + 1;
            cntb = fb ? 0 : cntb + 1;
        end
        rdy_ok = 1'b1;
        check_outputs(tag);
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic l, input logic wr);
        step(tag, 1'b1, d, 4'hF, 4'hF, 2'b00, 2'b01, l, wr, 1'b0);
    endtask

    task automatic idle(input string tag, input logic wr, input logic clr);
        step(tag, 1'b0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, wr, clr);
    endtask

    initial begin
        model_reset();
        #1;
        chk("reset_rdy_low", 64'(rdy_a), 64'd0);
        chk("reset_vld", 64'(vld_a), 64'd0);
        chk("reset_din_a", 64'(din_a), 64'd0);
        chk("reset_din_b", 64'(din_b), 64'd0);
        chk("reset_pkt", 64'(pkt_a), 64'd0);
        repeat (2) @(posedge axis_clk);
        @(negedge axis_clk);
        axi_reset_n = 1'b1;
        chk("rdy_before_first_edge", 64'(rdy_a), 64'd0);
        @(posedge axis_clk);
        #1;
        rdy_ok = 1'b1;
        check_outputs("post_reset");

        // streaming, 10 beats
        for (int i = 0; i < 10; i++) beat("stream", 32'(i), i == 9, 1'b1);
        idle("stream_tail", 1'b1, 1'b0);
        idle("stream_tail", 1'b1, 1'b0);

        // packing
        step("pack", 1'b1, 32'hDEADBEEF, 4'h3, 4'hF, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0);
        chk("pack_const", 64'(din_a), 64'h13F3DEADBEEF);
        idle("pack_tail", 1'b1, 1'b0);

        // backpressure: w_rdy low for 5 cycles mid-stream
        for (int i = 0; i < 3; i++) beat("bp_pre", 32'h100 + 32'(i), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) beat("bp_stall", 32'h200 + 32'(i), 1'b0, 1'b0);
        chk("bp_stalled_rdy", 64'(rdy_a), 64'd0);
        for (int i = 0; i < 4; i++) beat("bp_post", 32'h300 + 32'(i), i == 3, 1'b1);
        for (int i = 0; i < 3; i++) idle("bp_drain", 1'b1, 1'b0);

        // oversize on the MAX_BEATS=4 instance: 6-beat packet
        for (int i = 0; i < 6; i++) beat("over", 32'h400 + 32'(i), i == 5, 1'b1);
        chk("over_err_b", 64'(err_b), 64'd1);
        chk("over_err_a", 64'(err_a), 64'd0);
        idle("over_tail", 1'b1, 1'b0);
        idle("over_clr", 1'b1, 1'b1);
        chk("over_err_cleared", 64'(err_b), 64'd0);

        // randomized traffic
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom), 4'($urandom),
                 2'($urandom), 2'($urandom), 1'($urandom_range(0, 6) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));

        // build an error and a full buffer, then reset asynchronously while in TWO
        for (int i = 0; i < 5; i++) beat("pre_rst", 32'h500 + 32'(i), 1'b0, 1'b1);
        beat("pre_rst_two", 32'h600, 1'b0, 1'b0);
        beat("pre_rst_two", 32'h601, 1'b0, 1'b0);
        chk("in_two", 64'(rdy_a), 64'd0);
        #2;
        axi_reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_vld_a", 64'(vld_a), 64'd0);
        chk("async_rst_vld_b", 64'(vld_b), 64'd0);
        chk("async_rst_err_b", 64'(err_b), 64'd0);
        chk("async_rst_pkt_b", 64'(pkt_b), 64'd0);
        chk("async_rst_rdy", 64'(rdy_a), 64'd0);
        s_tvalid = 1'b0;
        @(negedge axis_clk);
        axi_reset_n = 1'b1;
        @(posedge axis_clk);
        #1;
        rdy_ok = 1'b1;
        check_outputs("rst_release");
        beat("one_beat_pkt", 32'h777, 1'b1, 1'b1);
        idle("one_beat_tail", 1'b1, 1'b0);
`ifdef FSIC_INGRESS_PKT_CNT_EN
        chk("one_beat_pkt_cnt", 64'(pkt_a), 64'd1);
`else
        chk("one_beat_pkt_cnt_off", 64'(pkt_a), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
